// File: rtl/ctrl_sequencer_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for ctrl_sequencer.
// Flag logic elsewhere is built only when SEQ_FLAGS_EN is defined.
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDI = 4'd1,
        OP_MOV = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_e;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned D_LSB  = 9;
    localparam int unsigned A_LSB  = 6;
    localparam int unsigned B_LSB  = 3;
    localparam int unsigned IMM_W  = 9;

    function automatic logic [3:0] instr_op(input logic [15:0] instr);
        return instr[OP_LSB +: 4];
    endfunction

    function automatic logic [SEL_W-1:0] instr_d(input logic [15:0] instr);
        return instr[D_LSB +: SEL_W];
    endfunction

    function automatic logic [SEL_W-1:0] instr_a(input logic [15:0] instr);
        return instr[A_LSB +: SEL_W];
    endfunction

    function automatic logic [SEL_W-1:0] instr_b(input logic [15:0] instr);
        return instr[B_LSB +: SEL_W];
    endfunction

    function automatic logic [IMM_W-1:0] instr_imm(input logic [15:0] instr);
        return instr[IMM_W-1:0];
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_SHR;
    endfunction

    // Ops that produce a write-back result (LDI..SHR).
    function automatic logic op_writes(input logic [3:0] op);
        return (op != OP_NOP) && !op_illegal(op);
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction handshake and register-file bus between ctrl_sequencer and its environment.
// master = sequencer side, slave = instruction source / register file side.
interface ctrl_sequencer_if;
    logic [15:0] INSTR;
    logic        IVALID;
    logic        IREADY;
    logic [15:0] ABUS;
    logic [15:0] BBUS;
    logic [2:0]  ASEL;
    logic [2:0]  BSEL;
    logic [2:0]  DSEL;
    logic [15:0] DIN;
    logic [15:0] RIN;
    logic        DONE;
    logic        ILLEGAL;
    logic        ZF;
    logic        CF;
    logic        NF;

    modport master (
        input  INSTR, IVALID, ABUS, BBUS,
        output IREADY, ASEL, BSEL, DSEL, DIN, RIN, DONE, ILLEGAL, ZF, CF, NF
    );

    modport slave (
        output INSTR, IVALID, ABUS, BBUS,
        input  IREADY, ASEL, BSEL, DSEL, DIN, RIN, DONE, ILLEGAL, ZF, CF, NF
    );
endinterface

// File: rtl/ctrl_sequencer_alu.sv
// Combinational datapath for ctrl_sequencer: result and carry/borrow/shifted-out bit.
module seq_alu
    import ctrl_seq_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        carry
);

    logic [16:0] wide;

    // SHL carries out of bit 16; SHR shifts through an extra LSB so the
    // last bit shifted out lands in wide[0].
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_LDI, OP_MOV: wide = {1'b0, a};
            OP_ADD:         wide = {1'b0, a} + {1'b0, b};
            OP_SUB:         wide = {1'b0, a} - {1'b0, b};
            OP_AND:         wide = {1'b0, a & b};
            OP_OR:          wide = {1'b0, a | b};
            OP_XOR:         wide = {1'b0, a ^ b};
            OP_SHL:         wide = {1'b0, a} << b[3:0];
            OP_SHR:         wide = {a, 1'b0} >> b[3:0];
            default:        wide = '0;
        endcase
        if (op == OP_SHR) begin
            result = wide[16:1];
            carry  = wide[0];
        end else begin
            result = wide[15:0];
            carry  = wide[16];
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Four-state instruction sequencer (IDLE/READ/EXEC/WRITE) driving a register file.
// Define SEQ_FLAGS_EN to build the ZF/CF/NF flag registers; otherwise flags are tied 0.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
(
    input logic              CLK,
    input logic              RST,
    ctrl_sequencer_if.master bus
);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  dst_q, dst_d;
    logic [2:0]  asel_q, asel_d;
    logic [2:0]  bsel_q, bsel_d;
    logic [2:0]  dsel_q, dsel_d;
    logic [15:0] din_q, din_d;
    logic [15:0] rin_q, rin_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [15:0] alu_result;
    logic        alu_carry;
`ifdef SEQ_FLAGS_EN
    logic        zf_q, zf_d;
    logic        cf_q, cf_d;
    logic        nf_q, nf_d;
`endif

    seq_alu u_alu (
        .op     (op_q),
        .a      (bus.ABUS),
        .b      (bus.BBUS),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        asel_d    = asel_q;
        bsel_d    = bsel_q;
        din_d     = din_q;
        rin_d     = rin_q;
        dsel_d    = '0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef SEQ_FLAGS_EN
        zf_d      = zf_q;
        cf_d      = cf_q;
        nf_d      = nf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.IVALID) begin
                    op_d    = instr_op(bus.INSTR);
                    dst_d   = instr_d(bus.INSTR);
                    state_d = ST_READ;
                    if (op_illegal(instr_op(bus.INSTR))) begin
                        illegal_d = 1'b1;
                        asel_d    = '0;
                        bsel_d    = '0;
                        din_d     = '0;
                    end else if (instr_op(bus.INSTR) == OP_LDI) begin
                        asel_d = '0;
                        bsel_d = instr_b(bus.INSTR);
                        din_d  = {{(DATA_W-IMM_W){1'b0}}, instr_imm(bus.INSTR)};
                    end else begin
                        asel_d = instr_a(bus.INSTR);
                        bsel_d = instr_b(bus.INSTR);
                        din_d  = '0;
                    end
                end
            end
            ST_READ: begin
                state_d = op_illegal(op_q) ? ST_IDLE : ST_EXEC;
            end
            // Selects and DIN stay put through EXEC so LDI still reads its immediate on ABUS.
            ST_EXEC: begin
                rin_d   = alu_result;
                dsel_d  = op_writes(op_q) ? dst_q : '0;
                done_d  = 1'b1;
                state_d = ST_WRITE;
`ifdef SEQ_FLAGS_EN
                if (op_writes(op_q)) begin
                    zf_d = (alu_result == '0);
                    nf_d = alu_result[15];
                    cf_d = alu_carry;
                end
`endif
            end
            ST_WRITE: begin
                asel_d  = '0;
                bsel_d  = '0;
                din_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            asel_q    <= '0;
            bsel_q    <= '0;
            dsel_q    <= '0;
            din_q     <= '0;
            rin_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef SEQ_FLAGS_EN
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            nf_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            asel_q    <= asel_d;
            bsel_q    <= bsel_d;
            dsel_q    <= dsel_d;
            din_q     <= din_d;
            rin_q     <= rin_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef SEQ_FLAGS_EN
            zf_q      <= zf_d;
            cf_q      <= cf_d;
            nf_q      <= nf_d;
`endif
        end
    end

    assign bus.IREADY  = (state_q == ST_IDLE);
    assign bus.ASEL    = asel_q;
    assign bus.BSEL    = bsel_q;
    assign bus.DSEL    = dsel_q;
    assign bus.DIN     = din_q;
    assign bus.RIN     = rin_q;
    assign bus.DONE    = done_q;
    assign bus.ILLEGAL = illegal_q;
`ifdef SEQ_FLAGS_EN
    assign bus.ZF      = zf_q;
    assign bus.CF      = cf_q;
    assign bus.NF      = nf_q;
`else
    assign bus.ZF      = 1'b0;
    assign bus.CF      = 1'b0;
    assign bus.NF      = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: vector table plus scoreboard, with hand-written
// sequences for reset, LDI timing, illegal opcodes, abort-by-reset and back-to-back streaming.
module tb_ctrl_sequencer;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  d;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [8:0]  imm;
        logic [15:0] abus;
        logic [15:0] bbus;
        logic [15:0] rin;
        logic        z;
        logic        c;
        logic        n;
    } vec_t;

    typedef struct {
        logic        ill;
        logic        chk_rin;
        logic [15:0] rin;
        logic [2:0]  dsel;
        logic        upd;
        logic        z;
        logic        c;
        logic        n;
    } sb_t;

    logic        CLK;
    logic        RST;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        mz, mc, mn;
    int unsigned total;
    int unsigned bad;
    sb_t         sb[$];
    vec_t        tv[17];

    ctrl_sequencer_if bus();

    ctrl_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model: select 0 returns DIN, anything else returns the driven operand.
    always_comb begin
        bus.ABUS = (bus.ASEL == 3'd0) ? bus.DIN : a_drv;
        bus.BBUS = (bus.BSEL == 3'd0) ? bus.DIN : b_drv;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_flags(input string name);
`ifdef SEQ_FLAGS_EN
        chk({name, "_zf"}, {31'd0, bus.ZF}, {31'd0, mz});
        chk({name, "_cf"}, {31'd0, bus.CF}, {31'd0, mc});
        chk({name, "_nf"}, {31'd0, bus.NF}, {31'd0, mn});
`else
        chk({name, "_zf"}, {31'd0, bus.ZF}, 32'd0);
        chk({name, "_cf"}, {31'd0, bus.CF}, 32'd0);
        chk({name, "_nf"}, {31'd0, bus.NF}, 32'd0);
`endif
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            if (!bus.DONE)
                chk("dsel_outside_write", {29'd0, bus.DSEL}, 32'd0);
            if (bus.DONE || bus.ILLEGAL) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", {31'd0, bus.DONE}, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("illegal_pulse", {31'd0, bus.ILLEGAL}, {31'd0, e.ill});
                    chk("done_pulse", {31'd0, bus.DONE}, {31'd0, !e.ill});
                    if (!e.ill) begin
                        chk("dsel", {29'd0, bus.DSEL}, {29'd0, e.dsel});
                        if (e.chk_rin)
                            chk("rin", {16'd0, bus.RIN}, {16'd0, e.rin});
                    end
                    if (e.upd) begin
                        mz = e.z;
                        mc = e.c;
                        mn = e.n;
                    end
                    chk_flags("flags");
                end
            end
        end
    end

    function automatic logic [15:0] mk_instr(input vec_t v);
        if (v.op == 4'd1)
            return {v.op, v.d, v.imm};
        return {v.op, v.d, v.a, v.b, 3'b000};
    endfunction

    function automatic sb_t mk_exp(input vec_t v);
        sb_t e;
        e.ill     = (v.op > 4'd9);
        e.chk_rin = (v.op != 4'd0) && !e.ill;
        e.upd     = e.chk_rin;
        e.rin     = v.rin;
        e.dsel    = e.chk_rin ? v.d : 3'd0;
        e.z       = v.z;
        e.c       = v.c;
        e.n       = v.n;
        return e;
    endfunction

    task automatic send(input logic [15:0] instr, input logic [15:0] av, input logic [15:0] bv,
                        input logic push, input sb_t e);
        int unsigned n;
        n = 0;
        @(negedge CLK);
        while (!bus.IREADY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.IREADY) begin
            chk("ready_timeout", {31'd0, bus.IREADY}, 32'd1);
        end else begin
            bus.INSTR  = instr;
            bus.IVALID = 1'b1;
            a_drv      = av;
            b_drv      = bv;
            if (push)
                sb.push_back(e);
            @(posedge CLK);
            #1 bus.IVALID = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", sb.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_asel"},    {29'd0, bus.ASEL},    32'd0);
        chk({tag, "_bsel"},    {29'd0, bus.BSEL},    32'd0);
        chk({tag, "_dsel"},    {29'd0, bus.DSEL},    32'd0);
        chk({tag, "_din"},     {16'd0, bus.DIN},     32'd0);
        chk({tag, "_rin"},     {16'd0, bus.RIN},     32'd0);
        chk({tag, "_done"},    {31'd0, bus.DONE},    32'd0);
        chk({tag, "_illegal"}, {31'd0, bus.ILLEGAL}, 32'd0);
        chk({tag, "_zf"},      {31'd0, bus.ZF},      32'd0);
        chk({tag, "_cf"},      {31'd0, bus.CF},      32'd0);
        chk({tag, "_nf"},      {31'd0, bus.NF},      32'd0);
    endtask

    initial begin
        sb_t  e;
        vec_t v;
        int unsigned acc;

        total = 0;
        bad   = 0;
        mz = 1'b0; mc = 1'b0; mn = 1'b0;
        a_drv = '0;
        b_drv = '0;
        bus.INSTR  = '0;
        bus.IVALID = 1'b0;
        RST = 1'b0;

        //        op     d     a     b     imm       abus      bbus      rin       z     c     n
        tv[0]  = '{4'd1, 3'd4, 3'd0, 3'd0, 9'h1FF, 16'h0000, 16'h0000, 16'h01FF, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{4'd3, 3'd1, 3'd1, 3'd2, 9'h000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{4'd4, 3'd2, 3'd3, 3'd4, 9'h000, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{4'd2, 3'd4, 3'd5, 3'd1, 9'h000, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{4'd5, 3'd5, 3'd1, 3'd2, 9'h000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{4'd6, 3'd6, 3'd2, 3'd3, 9'h000, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{4'd7, 3'd7, 3'd4, 3'd4, 9'h000, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{4'd8, 3'd1, 3'd1, 3'd2, 9'h000, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{4'd9, 3'd2, 3'd1, 3'd2, 9'h000, 16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{4'd0, 3'd5, 3'd1, 3'd2, 9'h000, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0};
        tv[10] = '{4'hF, 3'd3, 3'd1, 3'd2, 9'h000, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0};
        tv[11] = '{4'd8, 3'd3, 3'd6, 3'd7, 9'h000, 16'h0011, 16'h0004, 16'h0110, 1'b0, 1'b0, 1'b0};
        tv[12] = '{4'd3, 3'd0, 3'd1, 3'd2, 9'h000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
        tv[13] = '{4'd9, 3'd6, 3'd2, 3'd1, 9'h000, 16'h8000, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0};
        tv[14] = '{4'd4, 3'd7, 3'd1, 3'd2, 9'h000, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        tv[15] = '{4'd3, 3'd1, 3'd3, 3'd4, 9'h000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        tv[16] = '{4'd8, 3'd2, 3'd1, 3'd2, 9'h000, 16'hFFFF, 16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        chk("reset_iready", {31'd0, bus.IREADY}, 32'd1);
        RST = 1'b1;

        // LDI D=3 imm=0x05: operand routing in READ, write-back three cycles after accept.
        v = '{4'd1, 3'd3, 3'd0, 3'd0, 9'h005, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0};
        send(mk_instr(v), 16'hDEAD, 16'hBEEF, 1'b1, mk_exp(v));
        @(negedge CLK);
        chk("ldi_read_asel", {29'd0, bus.ASEL}, 32'd0);
        chk("ldi_read_din", {16'd0, bus.DIN}, 32'h0005);
        chk("ldi_read_iready", {31'd0, bus.IREADY}, 32'd0);
        @(negedge CLK);
        chk("ldi_exec_done", {31'd0, bus.DONE}, 32'd0);
        @(negedge CLK);
        chk("ldi_write_dsel", {29'd0, bus.DSEL}, 32'd3);
        chk("ldi_write_rin", {16'd0, bus.RIN}, 32'h0005);
        @(negedge CLK);
        chk("ldi_iready_back", {31'd0, bus.IREADY}, 32'd1);
        chk("ldi_done_single", {31'd0, bus.DONE}, 32'd0);

        for (int i = 0; i < 17; i++)
            send(mk_instr(tv[i]), tv[i].abus, tv[i].bbus, 1'b1, mk_exp(tv[i]));
        drain();

        // Opcode 0xC: ILLEGAL for one cycle, straight back to IDLE.
        v = '{4'hC, 3'd5, 3'd1, 3'd2, 9'h000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        send(mk_instr(v), 16'h1234, 16'h5678, 1'b1, mk_exp(v));
        @(negedge CLK);
        chk("ill_pulse", {31'd0, bus.ILLEGAL}, 32'd1);
        @(negedge CLK);
        chk("ill_iready_back", {31'd0, bus.IREADY}, 32'd1);
        chk("ill_pulse_end", {31'd0, bus.ILLEGAL}, 32'd0);
        drain();

        // SHL D=7 stream with IVALID held for 12 edges.
        v = '{4'd8, 3'd7, 3'd1, 3'd2, 9'h000, 16'h0011, 16'h0004, 16'h0110, 1'b0, 1'b0, 1'b0};
        acc = 0;
        @(negedge CLK);
        bus.INSTR  = mk_instr(v);
        a_drv      = v.abus;
        b_drv      = v.bbus;
        bus.IVALID = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.IREADY) begin
                acc++;
                sb.push_back(mk_exp(v));
            end
            @(negedge CLK);
        end
        bus.IVALID = 1'b0;
        chk("stream_accepts", acc, 32'd3);
        drain();

        // Reset during EXEC of MOV D=2 aborts without a write.
        v = '{4'd2, 3'd2, 3'd1, 3'd2, 9'h000, 16'h5555, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b0};
        e = mk_exp(v);
        send(mk_instr(v), v.abus, v.bbus, 1'b0, e);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_all_zero("abort");
        chk("abort_iready", {31'd0, bus.IREADY}, 32'd1);
        mz = 1'b0; mc = 1'b0; mn = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_first_edge_iready", {31'd0, bus.IREADY}, 32'd1);
        chk("abort_no_write", {29'd0, bus.DSEL}, 32'd0);
        send(mk_instr(v), v.abus, v.bbus, 1'b1, e);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port INSTR  input  16  instruction: [15:12] op, [11:9] D, [8:6] A, [5:3] B, [8:0] imm9 (LDI only).
REQ-004 SHALL have port IVALID  input  1  INSTR valid.
REQ-005 SHALL have port IREADY  output  1  sequencer can accept INSTR.
REQ-006 SHALL have ports ABUS, BBUS  input  16  register-file read data.
REQ-007 SHALL have ports ASEL, BSEL, DSEL  output  3  register-file selects; 0 on ASEL/BSEL selects DIN, DSEL=0 means no write.
REQ-008 SHALL have port DIN  output  16  immediate/external operand to register file.
REQ-009 SHALL have port RIN  output  16  write-back data to register file.
REQ-010 SHALL have ports DONE, ILLEGAL  output  1  single-cycle completion / bad-opcode pulses.
REQ-011 SHALL have ports ZF, CF, NF  output  1  flags (see Configuration).

Function
REQ-012 SHALL implement FSM IDLE -> READ -> EXEC -> WRITE -> IDLE; IREADY=1 only in IDLE.
REQ-013 SHALL capture INSTR on the edge where IVALID && IREADY; IVALID without IREADY is ignored, no buffering.
REQ-014 In READ: ASEL=A, BSEL=B, DIN=zero-extended imm9 for LDI else 0; LDI forces ASEL=0.
REQ-015 In EXEC: SHALL register ABUS/BBUS result into RIN; ASEL/BSEL held from READ.
REQ-016 In WRITE: DSEL=D for exactly one cycle, RIN stable, DONE=1; DSEL=0 in every other state.
REQ-017 Ops: 0 NOP, 1 LDI (RIN=A-operand), 2 MOV (RIN=ABUS), 3 ADD, 4 SUB (ABUS-BBUS), 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR (shift ABUS by BBUS[3:0], zero fill); all arithmetic mod 2^16.
REQ-018 NOP or D=0: full FSM traversal, DSEL stays 0, DONE still pulses in WRITE.
REQ-019 Opcodes 10-15: go IDLE -> READ -> IDLE, ILLEGAL=1 for the READ cycle, no DONE, no write.
REQ-020 Latency: accept at edge N, DSEL valid cycle N+3, IREADY high again cycle N+4; throughput one instruction per 4 cycles.

Reset
REQ-021 RST low SHALL immediately force state IDLE; ASEL, BSEL, DSEL, DIN, RIN, DONE, ILLEGAL, ZF, CF, NF = 0.
REQ-022 Reset mid-instruction SHALL abort it with no register write; IREADY=1 on first edge after RST released.

Configuration
REQ-023 With SEQ_FLAGS_EN defined: ZF/NF updated from RIN result on every write-back op (LDI..SHR), CF = carry-out on ADD, borrow on SUB, last shifted-out bit on SHL/SHR, 0 otherwise; flags held across NOP/illegal.
REQ-024 Without SEQ_FLAGS_EN: ZF, CF, NF tied 0, no flag registers.

Structure
REQ-025 Opcode constants, FSM state encoding and field bit positions SHALL live in shared package ctrl_seq_pkg.
REQ-026 Datapath SHALL be a combinational sub-module seq_alu (op, a, b -> result, carry).

Verification
REQ-027 Reset, then INSTR=LDI D=3 imm=0x05 -> ASEL=0, DIN=0x0005 in READ; DSEL=3, RIN=0x0005, DONE in cycle N+3.
REQ-028 ABUS=0xFFFF, BBUS=0x0001, ADD D=1 -> RIN=0x0000, DSEL=1; with SEQ_FLAGS_EN ZF=1, CF=1, NF=0.
REQ-029 SUB with ABUS=0x0003, BBUS=0x0005 -> RIN=0xFFFE, CF=1, NF=1 (flags build).
REQ-030 Opcode 0xC with IVALID -> ILLEGAL one cycle, DSEL never nonzero, IREADY back after 2 cycles.
REQ-031 RST asserted during EXEC of MOV D=2 -> DSEL stays 0, all outputs 0, next instruction accepted normally.
REQ-032 IVALID held high for 12 cycles with SHL D=7 stream, BBUS=0x0004, ABUS=0x0011 -> exactly 3 accepts, each RIN=0x0110.
